// File: rtl/audio_stream_pkg.sv
// Shared constants and helpers for the audio sample streaming path.
package audio_stream_pkg;

    localparam int SAMPLE_W      = 16;
    localparam int AXIS_DATA_W   = 32;
    localparam int FFT_FRAME_LEN = 1024;

    // Widen a signed PCM sample to the AXI-Stream data width.
    function automatic logic [AXIS_DATA_W-1:0] sext_sample(input logic [SAMPLE_W-1:0] s);
        return {{(AXIS_DATA_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
    endfunction

endpackage

// File: rtl/sample_axis_source_if.sv
// AXI4-Stream beat bundle carrying widened audio samples.
interface sample_axis_source_if;
    import audio_stream_pkg::*;

    logic [AXIS_DATA_W-1:0] tdata;
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: the head entry is visible on rd_data
// whenever the FIFO is not empty. Writes to a full FIFO are accepted only
// when a read frees a slot in the same cycle.
module sync_fifo_fwft #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign rd_ok   = rd_en & ~empty;
    assign wr_ok   = wr_en & (~full | rd_ok);
    assign rd_data = mem[rd_ptr];

    // Store the incoming word at the tail.
    // NOTE: the storage array has no reset; emptiness is tracked by the
    // level counter, so stale words are never presented as valid data.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    // Advance pointers and occupancy; clear and reset both empty the FIFO.
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, so level and pointers update consistently.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sample_axis_source.sv
// AXI4-Stream master feeding captured audio samples to the draw/analysis
// blocks: buffers strobed samples, sign-extends them, marks FFT frame
// boundaries with tlast and keeps drop statistics.
module sample_axis_source #(
    parameter  int SAMPLE_W   = audio_stream_pkg::SAMPLE_W,
    parameter  int FIFO_DEPTH = 16,
    parameter  int FRAME_LEN  = audio_stream_pkg::FFT_FRAME_LEN,
    parameter  int DROP_CNT_W = 16,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  m00_axis_aclk,
    input  logic                  m00_axis_aresetn,
    input  logic                  enable,
    input  logic                  flush,
    input  logic [SAMPLE_W-1:0]   sample_in,
    input  logic                  sample_valid,
    sample_axis_source_if.master  m00_axis,
    output logic [LVL_W-1:0]      fifo_level,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] dropped_count
);
    import audio_stream_pkg::*;

    localparam int BEAT_W = $clog2(FRAME_LEN);

    logic [SAMPLE_W-1:0] head_sample;
    logic                fifo_empty;
    logic                fifo_full;
    logic                wr_req;
    logic                handshake;
    logic                drop;
    logic [BEAT_W-1:0]   beat_idx;

    // A strobe during flush is discarded outright and never counts as a drop.
    assign wr_req    = sample_valid & enable & ~flush;
    assign handshake = m00_axis.tvalid & m00_axis.tready;
    // A full FIFO still takes the sample if the head leaves this cycle.
    assign drop      = wr_req & fifo_full & ~handshake;

    sync_fifo_fwft #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (m00_axis_aclk),
        .rst_n   (m00_axis_aresetn),
        .clr     (flush),
        .wr_en   (wr_req),
        .wr_data (sample_in),
        .rd_en   (handshake),
        .rd_data (head_sample),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .level   (fifo_level)
    );

    // Output beat comes straight from the FIFO head, so it holds until taken.
    assign m00_axis.tvalid = ~fifo_empty;
    assign m00_axis.tdata  = fifo_empty ? '0 : AXIS_DATA_W'($signed(head_sample));
    assign m00_axis.tlast  = ~fifo_empty & (beat_idx == BEAT_W'(FRAME_LEN - 1));

    // Frame position follows transmitted beats; drop statistics saturate.
    always_ff @(posedge m00_axis_aclk) begin
        if (!m00_axis_aresetn || flush) begin
            beat_idx      <= '0;
            overflow      <= 1'b0;
            dropped_count <= '0;
        end else begin
            if (handshake) beat_idx <= beat_idx + BEAT_W'(1);
            if (drop) begin
                overflow <= 1'b1;
                if (dropped_count != '1) dropped_count <= dropped_count + DROP_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sample_axis_source.sv
// Directed self-checking bench for sample_axis_source.
module tb_sample_axis_source;

    localparam int FIFO_DEPTH = 16;
    localparam int FRAME_LEN  = 1024;
    localparam int DROP_CNT_W = 16;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_in = '0;
    logic [LVL_W-1:0]      fifo_level;
    logic                  overflow;
    logic [DROP_CNT_W-1:0] dropped_count;

    int vectors = 0;
    int miscompares = 0;

    sample_axis_source_if m00_axis ();

    sample_axis_source #(
        .SAMPLE_W   (16),
        .FIFO_DEPTH (FIFO_DEPTH),
        .FRAME_LEN  (FRAME_LEN),
        .DROP_CNT_W (DROP_CNT_W)
    ) dut (
        .m00_axis_aclk    (clk),
        .m00_axis_aresetn (aresetn),
        .enable           (enable),
        .flush            (flush),
        .sample_in        (sample_in),
        .sample_valid     (sample_valid),
        .m00_axis         (m00_axis),
        .fifo_level       (fifo_level),
        .overflow         (overflow),
        .dropped_count    (dropped_count)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; enable = 1'b1; m00_axis.tready = 1'b0;
        sample_valid = 1'b1; sample_in = 16'h1111;
        tick(); tick();
        vectors++; if (m00_axis.tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid: got %b expected 0", m00_axis.tvalid); end
        vectors++; if (m00_axis.tdata !== 32'h0) begin miscompares++; $display("FAIL reset_tdata: got %h expected 00000000", m00_axis.tdata); end
        vectors++; if (m00_axis.tlast !== 1'b0) begin miscompares++; $display("FAIL reset_tlast: got %b expected 0", m00_axis.tlast); end
        vectors++; if (fifo_level !== '0) begin miscompares++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        vectors++; if (dropped_count !== '0) begin miscompares++; $display("FAIL reset_dropped: got %0d expected 0", dropped_count); end
        sample_valid = 1'b0;
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_single_beat();
        sample_in = 16'h8001; sample_valid = 1'b1; m00_axis.tready = 1'b1;
        tick();
        sample_valid = 1'b0;
        vectors++; if (m00_axis.tvalid !== 1'b1) begin miscompares++; $display("FAIL single_tvalid: got %b expected 1", m00_axis.tvalid); end
        vectors++; if (m00_axis.tdata !== 32'hFFFF8001) begin miscompares++; $display("FAIL single_tdata: got %h expected ffff8001", m00_axis.tdata); end
        vectors++; if (fifo_level !== LVL_W'(1)) begin miscompares++; $display("FAIL single_level1: got %0d expected 1", fifo_level); end
        tick();
        vectors++; if (m00_axis.tvalid !== 1'b0) begin miscompares++; $display("FAIL single_tvalid_after: got %b expected 0", m00_axis.tvalid); end
        vectors++; if (fifo_level !== '0) begin miscompares++; $display("FAIL single_level0: got %0d expected 0", fifo_level); end
    endtask

    task automatic test_overflow_and_full_write();
        logic [31:0] exp_data;
        m00_axis.tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sample_in = 16'(i); sample_valid = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
        vectors++; if (fifo_level !== LVL_W'(16)) begin miscompares++; $display("FAIL ovf_level: got %0d expected 16", fifo_level); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        vectors++; if (dropped_count !== 16'd4) begin miscompares++; $display("FAIL ovf_dropped: got %0d expected 4", dropped_count); end
        vectors++; if ({m00_axis.tvalid, m00_axis.tdata} !== {1'b1, 32'h0}) begin miscompares++; $display("FAIL ovf_head: got %b/%h expected 1/00000000", m00_axis.tvalid, m00_axis.tdata); end
        // Full FIFO: read and write in the same cycle, no drop.
        sample_in = 16'd100; sample_valid = 1'b1; m00_axis.tready = 1'b1;
        tick();
        sample_valid = 1'b0;
        vectors++; if (fifo_level !== LVL_W'(16)) begin miscompares++; $display("FAIL fullrw_level: got %0d expected 16", fifo_level); end
        vectors++; if (dropped_count !== 16'd4) begin miscompares++; $display("FAIL fullrw_dropped: got %0d expected 4", dropped_count); end
        // Drain: samples 1..15 then 100 with no gaps.
        for (int k = 0; k < 16; k++) begin
            exp_data = (k < 15) ? 32'(k + 1) : 32'd100;
            vectors++; if ({m00_axis.tvalid, m00_axis.tdata} !== {1'b1, exp_data}) begin miscompares++; $display("FAIL drain_beat%0d: got %b/%h expected 1/%h", k, m00_axis.tvalid, m00_axis.tdata, exp_data); end
            tick();
        end
        vectors++; if (m00_axis.tvalid !== 1'b0) begin miscompares++; $display("FAIL drain_empty: got %b expected 0", m00_axis.tvalid); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL drain_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_flush_clears();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL flush_overflow: got %b expected 0", overflow); end
        vectors++; if (dropped_count !== '0) begin miscompares++; $display("FAIL flush_dropped: got %0d expected 0", dropped_count); end
        vectors++; if (fifo_level !== '0) begin miscompares++; $display("FAIL flush_level: got %0d expected 0", fifo_level); end
    endtask

    // 2048 samples; rnd selects a sparse source with a 50% random consumer.
    task automatic test_frame_stream(input bit rnd);
        logic [15:0] q[$];
        logic [15:0] d;
        logic [31:0] exp_data;
        bit   rdy;
        bit   sv;
        bit   rd;
        int   sent = 0;
        int   got = 0;
        int   drops = 0;
        int   lasts = 0;
        int   cycles = 0;
        bit   exp_last;
        while (!(sent == 2048 && q.size() == 0) && cycles < 20000) begin
            sv  = (sent < 2048) && (!rnd || (cycles % 3 == 0));
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            d   = 16'(sent * 40503);
            sample_valid = sv; sample_in = d; m00_axis.tready = rdy;
            vectors++; if (m00_axis.tvalid !== (q.size() > 0)) begin miscompares++; $display("FAIL stream_tvalid c%0d: got %b expected %b", cycles, m00_axis.tvalid, q.size() > 0); end
            if (q.size() > 0) begin
                exp_last = (got % FRAME_LEN) == FRAME_LEN - 1;
                exp_data = {{16{q[0][15]}}, q[0]};
                vectors++; if (m00_axis.tdata !== exp_data) begin miscompares++; $display("FAIL stream_tdata beat%0d: got %h expected %h", got, m00_axis.tdata, exp_data); end
                vectors++; if (m00_axis.tlast !== exp_last) begin miscompares++; $display("FAIL stream_tlast beat%0d: got %b expected %b", got, m00_axis.tlast, exp_last); end
            end
            rd = (q.size() > 0) && rdy;
            if (sv) begin
                if (q.size() < FIFO_DEPTH || rd) q.push_back(d);
                else drops++;
                sent++;
            end
            if (rd) begin
                if (exp_last) lasts++;
                void'(q.pop_front());
                got++;
            end
            tick();
            cycles++;
        end
        sample_valid = 1'b0;
        vectors++; if (cycles >= 20000) begin miscompares++; $display("FAIL stream_timeout: got %0d cycles expected < 20000", cycles); end
        vectors++; if (lasts !== got / FRAME_LEN) begin miscompares++; $display("FAIL stream_tlast_count: got %0d expected %0d", lasts, got / FRAME_LEN); end
        vectors++; if (dropped_count !== DROP_CNT_W'(drops)) begin miscompares++; $display("FAIL stream_dropped: got %0d expected %0d", dropped_count, drops); end
        if (!rnd) begin
            vectors++; if (got !== 2048) begin miscompares++; $display("FAIL stream_beats: got %0d expected 2048", got); end
        end
    endtask

    task automatic test_enable_gate();
        enable = 1'b0; m00_axis.tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample_in = 16'(i + 7); sample_valid = 1'b1;
            tick();
            vectors++; if (m00_axis.tvalid !== 1'b0) begin miscompares++; $display("FAIL enable0_tvalid%0d: got %b expected 0", i, m00_axis.tvalid); end
        end
        sample_valid = 1'b0;
        vectors++; if (dropped_count !== '0) begin miscompares++; $display("FAIL enable0_dropped: got %0d expected 0", dropped_count); end
        enable = 1'b1; sample_in = 16'h1234; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        vectors++; if ({m00_axis.tvalid, m00_axis.tdata} !== {1'b1, 32'h00001234}) begin miscompares++; $display("FAIL enable1_beat: got %b/%h expected 1/00001234", m00_axis.tvalid, m00_axis.tdata); end
        tick();
        vectors++; if (m00_axis.tvalid !== 1'b0) begin miscompares++; $display("FAIL enable1_single: got %b expected 0", m00_axis.tvalid); end
    endtask

    // Park the frame at beat 500 with 8 queued, then flush or reset.
    task automatic test_mid_clear(input bit use_reset);
        int sent = 0;
        int got = 0;
        int first_last = -1;
        int cycles = 0;
        flush = 1'b1; tick(); flush = 1'b0;
        enable = 1'b1; m00_axis.tready = 1'b1;
        for (int i = 0; i < 500; i++) begin
            sample_in = 16'(i); sample_valid = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
        tick();
        m00_axis.tready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sample_in = 16'(i + 600); sample_valid = 1'b1;
            tick();
        end
        vectors++; if (fifo_level !== LVL_W'(8)) begin miscompares++; $display("FAIL mid%0d_level8: got %0d expected 8", use_reset, fifo_level); end
        sample_in = 16'h0077; sample_valid = 1'b1;
        if (use_reset) aresetn = 1'b0; else flush = 1'b1;
        tick();
        aresetn = 1'b1; flush = 1'b0; sample_valid = 1'b0;
        vectors++; if ({m00_axis.tvalid, m00_axis.tdata} !== {1'b0, 32'h0}) begin miscompares++; $display("FAIL mid%0d_tvalid: got %b/%h expected 0/00000000", use_reset, m00_axis.tvalid, m00_axis.tdata); end
        vectors++; if (fifo_level !== '0) begin miscompares++; $display("FAIL mid%0d_level: got %0d expected 0", use_reset, fifo_level); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL mid%0d_overflow: got %b expected 0", use_reset, overflow); end
        m00_axis.tready = 1'b1;
        while (got < 1024 && cycles < 3000) begin
            sample_valid = (sent < 1024); sample_in = 16'(sent);
            if (m00_axis.tvalid && m00_axis.tready) begin
                got++;
                if (m00_axis.tlast && first_last < 0) first_last = got;
            end
            if (sample_valid) sent++;
            tick();
            cycles++;
        end
        sample_valid = 1'b0;
        vectors++; if (first_last !== 1024) begin miscompares++; $display("FAIL mid%0d_first_tlast: got beat %0d expected 1024", use_reset, first_last); end
    endtask

    initial begin
        m00_axis.tready = 1'b0;
        test_reset();
        test_single_beat();
        test_overflow_and_full_write();
        test_flush_clears();
        test_frame_stream(1'b0);
        flush = 1'b1; tick(); flush = 1'b0;
        test_frame_stream(1'b1);
        test_enable_gate();
        test_mid_clear(1'b0);
        test_mid_clear(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
